// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit; optional MULDIV_FAST_MUL_EN single-cycle multiply
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] r1_i,
    input  logic [XLEN-1:0] r2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_a;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_o;

    // operand signedness: div ops keyed on funct3[0], MULHSU has unsigned rs2, MULHU both unsigned
    logic              w_s1, w_s2, w_neg1, w_neg2;
    logic [XLEN-1:0]   w_mag1, w_mag2;
    logic              w_div0, w_ovf;
    logic [XLEN-1:0]   w_special;

    assign w_s1   = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
    assign w_s2   = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
    assign w_neg1 = w_s1 & r1_i[XLEN-1];
    assign w_neg2 = w_s2 & r2_i[XLEN-1];
    assign w_mag1 = w_neg1 ? (~r1_i + 1'b1) : r1_i;
    assign w_mag2 = w_neg2 ? (~r2_i + 1'b1) : r2_i;

    assign w_div0 = funct3_i[2] && (r2_i == '0);
    assign w_ovf  = funct3_i[2] && !funct3_i[0] &&
                    (r1_i == {1'b1, {(XLEN-1){1'b0}}}) && (r2_i == '1);
    // zero divisor: q = all ones, r = rs1; overflow: q = rs1 (most negative), r = 0
    assign w_special = w_div0 ? (funct3_i[1] ? r1_i : '1)
                              : (funct3_i[1] ? '0 : r1_i);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_mag, w_fast_prod;
    logic [XLEN-1:0]   w_fast_res;
    assign w_fast_mag  = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
    assign w_fast_prod = (w_neg1 ^ w_neg2) ? (~w_fast_mag + 1'b1) : w_fast_mag;
    assign w_fast_res  = (funct3_i[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0]
                                                  : w_fast_prod[2*XLEN-1:XLEN];
`endif

    // one iteration: hi/lo hold partial product (mul) or remainder/quotient (div); r_a is multiplicand or divisor
    logic [XLEN:0]     w_madd;
    logic [XLEN-1:0]   w_mul_hi, w_mul_lo;
    logic [XLEN:0]     w_dsh;
    logic              w_dge;
    logic [XLEN-1:0]   w_dsub, w_div_hi, w_div_lo;
    logic [XLEN-1:0]   w_hi_n, w_lo_n;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem, w_final;

    assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
    assign w_mul_hi = w_madd[XLEN:1];
    assign w_mul_lo = {w_madd[0], r_lo[XLEN-1:1]};

    assign w_dsh    = {r_hi, r_lo[XLEN-1]};
    assign w_dge    = (w_dsh >= {1'b0, r_a});
    assign w_dsub   = w_dsh[XLEN-1:0] - r_a;
    assign w_div_hi = w_dge ? w_dsub : w_dsh[XLEN-1:0];
    assign w_div_lo = {r_lo[XLEN-2:0], w_dge};

    assign w_hi_n   = r_funct3[2] ? w_div_hi : w_mul_hi;
    assign w_lo_n   = r_funct3[2] ? w_div_lo : w_mul_lo;

    // final result built from the last iteration's values so it can be registered entering DONE
    assign w_prod   = {w_hi_n, w_lo_n};
    assign w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quo    = r_neg_q ? (~w_lo_n + 1'b1) : w_lo_n;
    assign w_rem    = r_neg_r ? (~w_hi_n + 1'b1) : w_hi_n;
    assign w_final  = r_funct3[2] ? (r_funct3[1] ? w_rem : w_quo)
                                  : ((r_funct3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0]
                                                              : w_prod_s[2*XLEN-1:XLEN]);

    // control FSM with registered result/rd/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rd_o   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i && !flush_i) begin
                        r_funct3 <= funct3_i;
                        r_rd     <= rd_i;
                        r_hi     <= '0;
                        r_lo     <= funct3_i[2] ? w_mag1 : w_mag2;
                        r_a      <= funct3_i[2] ? w_mag2 : w_mag1;
                        r_neg_q  <= w_neg1 ^ w_neg2;
                        r_neg_r  <= w_neg1;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special;
                            r_rd_o   <= rd_i;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!funct3_i[2]) begin
                            r_result <= w_fast_res;
                            r_rd_o   <= rd_i;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
`endif
                        else begin
                            r_cnt   <= '0;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi  <= w_hi_n;
                        r_lo  <= w_lo_n;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(XLEN-1)) begin
                            r_result <= w_final;
                            r_rd_o   <= r_rd;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_req_o = (r_state == S_BUSY) ||
                         ((r_state == S_IDLE) && valid_i && !flush_i);
    assign done_o      = r_done;
    assign result_o    = r_result;
    assign rd_o        = r_rd_o;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
    localparam int B2B_GAP = 2;
`else
    localparam int MUL_LAT = 33;
    localparam int B2B_GAP = 34;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] r1_i, r2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_req_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int n_checks = 0;
    int n_fail   = 0;

    ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .funct3_i(funct3_i),
        .r1_i(r1_i), .r2_i(r2_i), .rd_i(rd_i), .flush_i(flush_i),
        .stall_req_o(stall_req_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
    );

    always #5 clk = ~clk;

    // drive one op from posedge+1, measure latency/result; returns at posedge+1 two cycles after done
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output logic [31:0] res,
                         output logic [4:0] rdo, output bit stall_ok, output bit extra_pulse);
        valid_i = 1'b1; funct3_i = f3; r1_i = a; r2_i = b; rd_i = rd;
        lat = -1; res = '0; rdo = '0; stall_ok = 1'b1; extra_pulse = 1'b0;
        @(negedge clk);
        if (!stall_req_o) stall_ok = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done_o) begin
                lat = k; res = result_o; rdo = rd_o;
                if (stall_req_o) stall_ok = 1'b0;
                break;
            end else if (!stall_req_o) begin
                stall_ok = 1'b0;
            end
        end
        @(negedge clk);
        extra_pulse = done_o;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; funct3_i = '0; r1_i = '0; r2_i = '0; rd_i = '0; flush_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done_o, stall_req_o, result_o, rd_o} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got done=%0b stall=%0b res=%h rd=%0d want all 0",
                     done_o, stall_req_o, result_o, rd_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mul_iterative();
        int lat; logic [31:0] res; logic [4:0] rdo; bit sok, ex;
        do_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd9, lat, res, rdo, sok, ex);
        n_checks++;
        if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mul_latency got %0d want %0d", lat, MUL_LAT); end
        n_checks++;
        if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result got %h want FFFFFFEB", res); end
        n_checks++;
        if (rdo !== 5'd9) begin n_fail++; $display("FAIL mul_rd got %0d want 9", rdo); end
        n_checks++;
        if (sok !== 1'b1) begin n_fail++; $display("FAIL mul_stall_window got %0b want 1", sok); end
        n_checks++;
        if (ex !== 1'b0) begin n_fail++; $display("FAIL mul_single_pulse got %0b want 0", ex); end
    endtask

    task automatic test_mulh();
        logic [2:0]  f3 [3]  = '{3'b011, 3'b001, 3'b010};
        logic [31:0] a  [3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b  [3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
        logic [31:0] exp [3] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
        int lat; logic [31:0] res; logic [4:0] rdo; bit sok, ex;
        for (int i = 0; i < 3; i++) begin
            do_op(f3[i], a[i], b[i], 5'(i + 1), lat, res, rdo, sok, ex);
            n_checks++;
            if (res !== exp[i] || lat !== MUL_LAT)
                begin n_fail++; $display("FAIL mulh_%0d got res=%h lat=%0d want res=%h lat=%0d", i, res, lat, exp[i], MUL_LAT); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3 [4]  = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a  [4]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] b  [4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        int lat; logic [31:0] res; logic [4:0] rdo; bit sok, ex;
        for (int i = 0; i < 4; i++) begin
            do_op(f3[i], a[i], b[i], 5'(20 + i), lat, res, rdo, sok, ex);
            n_checks++;
            if (res !== exp[i] || rdo !== 5'(20 + i) || lat !== DIV_LAT)
                begin n_fail++; $display("FAIL div_%0d got res=%h rd=%0d lat=%0d want res=%h rd=%0d lat=%0d",
                                         i, res, rdo, lat, exp[i], 20 + i, DIV_LAT); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3 [4]  = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] a  [4]  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] b  [4]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int lat; logic [31:0] res; logic [4:0] rdo; bit sok, ex;
        for (int i = 0; i < 4; i++) begin
            do_op(f3[i], a[i], b[i], 5'(10 + i), lat, res, rdo, sok, ex);
            n_checks++;
            if (res !== exp[i] || lat !== 1 || rdo !== 5'(10 + i) || sok !== 1'b1)
                begin n_fail++; $display("FAIL special_%0d got res=%h lat=%0d rd=%0d stall_ok=%0b want res=%h lat=1 rd=%0d stall_ok=1",
                                         i, res, lat, rdo, sok, exp[i], 10 + i); end
        end
    endtask

    task automatic test_abort_rst();
        int lat; logic [31:0] res; logic [4:0] rdo; bit sok, ex;
        bit seen_done = 1'b0;
        valid_i = 1'b1; funct3_i = 3'b101; r1_i = 32'd100; r2_i = 32'd7; rd_i = 5'd17;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({done_o, stall_req_o, result_o, rd_o} !== 39'd0) begin
            n_fail++;
            $display("FAIL rst_abort_outputs got done=%0b stall=%0b res=%h rd=%0d want all 0",
                     done_o, stall_req_o, result_o, rd_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o || stall_req_o) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rst_abort_no_done got activity=%0b want 0", seen_done); end
        @(posedge clk); #1;
        do_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd6, lat, res, rdo, sok, ex);
        n_checks++;
        if (res !== 32'hFFFFFFEB || rdo !== 5'd6 || lat !== MUL_LAT)
            begin n_fail++; $display("FAIL rst_recover got res=%h rd=%0d lat=%0d want res=FFFFFFEB rd=6 lat=%0d", res, rdo, lat, MUL_LAT); end
    endtask

    task automatic test_flush();
        bit seen_done = 1'b0;
        valid_i = 1'b1; funct3_i = 3'b111; r1_i = 32'd100; r2_i = 32'd7; rd_i = 5'd30;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        flush_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall_req_o !== 1'b1) begin n_fail++; $display("FAIL flush_busy_stall_same_cycle got %0b want 1", stall_req_o); end
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy_stall_next got %0b want 0", stall_req_o); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done got %0b want 0", seen_done); end
        @(posedge clk); #1;
        valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b100;
        @(negedge clk);
        n_checks++;
        if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall got %0b want 0", stall_req_o); end
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_req_o !== 1'b0 || done_o !== 1'b0)
            begin n_fail++; $display("FAIL flush_idle_not_accepted got stall=%0b done=%0b want 0 0", stall_req_o, done_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int cyc_d [2] = '{-1, -1};
        logic [31:0] res_d [2] = '{32'd0, 32'd0};
        logic [4:0]  rd_d  [2] = '{5'd0, 5'd0};
        int instr = 0;
        bit stall_s;
        valid_i = 1'b1; funct3_i = 3'b101; r1_i = 32'd100; r2_i = 32'd7; rd_i = 5'd3;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            stall_s = stall_req_o;
            if (done_o) begin
                if (n_done < 2) begin cyc_d[n_done] = c; res_d[n_done] = result_o; rd_d[n_done] = rd_o; end
                n_done++;
            end
            @(posedge clk); #1;
            if (!stall_s && instr < 2) begin
                instr++;
                if (instr == 1) begin funct3_i = 3'b000; r1_i = 32'd7; r2_i = 32'hFFFFFFFD; rd_i = 5'd4; end
                else valid_i = 1'b0;
            end
        end
        valid_i = 1'b0;
        n_checks++;
        if (n_done !== 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", n_done); end
        n_checks++;
        if (cyc_d[0] !== DIV_LAT || res_d[0] !== 32'd14 || rd_d[0] !== 5'd3)
            begin n_fail++; $display("FAIL b2b_first got cyc=%0d res=%h rd=%0d want cyc=%0d res=0000000e rd=3", cyc_d[0], res_d[0], rd_d[0], DIV_LAT); end
        n_checks++;
        if (cyc_d[1] - cyc_d[0] !== B2B_GAP || res_d[1] !== 32'hFFFFFFEB || rd_d[1] !== 5'd4)
            begin n_fail++; $display("FAIL b2b_second got gap=%0d res=%h rd=%0d want gap=%0d res=FFFFFFEB rd=4",
                                     cyc_d[1] - cyc_d[0], res_d[1], rd_d[1], B2B_GAP); end
    endtask

    initial begin
        test_reset();
        test_mul_iterative();
        test_mulh();
        test_div();
        test_special();
        test_abort_rst();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
